// File: rtl/spi_pkg.sv
// spi_pkg: SPI RAM command opcodes and the protocol state type shared by initiator and responder.
package spi_pkg;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizers for CS/SCK/MOSI plus SCK and CS edge pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cs_n,
  input  logic i_sck,
  input  logic i_mosi,
  output logic o_cs_n,
  output logic o_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise
);
  logic [1:0] r_cs_n_s, r_sck_s, r_mosi_s;
  logic r_cs_n_d, r_sck_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_n_s <= 2'b11;
      r_sck_s  <= 2'b00;
      r_mosi_s <= 2'b00;
      r_cs_n_d <= 1'b1;
      r_sck_d  <= 1'b0;
    end else begin
      r_cs_n_s <= {r_cs_n_s[0], i_cs_n};
      r_sck_s  <= {r_sck_s[0], i_sck};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_cs_n_d <= r_cs_n_s[1];
      r_sck_d  <= r_sck_s[1];
    end
  end
  assign o_cs_n     = r_cs_n_s[1];
  assign o_mosi     = r_mosi_s[1];
  assign o_sck_rise = r_sck_s[1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck_s[1] & r_sck_d;
  assign o_cs_fall  = ~r_cs_n_s[1] & r_cs_n_d;
  assign o_cs_rise  = r_cs_n_s[1] & ~r_cs_n_d;
endmodule

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 byte-addressed RAM target with READ/WRITE streaming,
// oversampled entirely in the clk domain.
module spi_ram_responder
  import spi_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  logic w_cs_n, w_mosi, w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_rise, w_fall, w_done, w_commit;
  logic [7:0] w_byte;
  logic [ADDR_W-1:0] w_byte_addr, w_addr_nx;
  state_t r_state, w_next;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic r_op_wr;
  logic [7:0] r_mem [2**ADDR_W];

  spi_pin_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cs_n     (spi_cs_n),
    .i_sck      (spi_sck),
    .i_mosi     (spi_mosi),
    .o_cs_n     (w_cs_n),
    .o_mosi     (w_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise)
  );

  assign w_rise      = w_sck_rise & ~w_cs_n;
  assign w_fall      = w_sck_fall & ~w_cs_n;
  assign w_byte      = {r_rx, w_mosi};
  // A CS rise discards any byte completing in the same cycle.
  assign w_done      = w_rise & (r_bit_cnt == 3'd7) & ~w_cs_rise;
  assign w_commit    = w_done & (r_state == WRITE);
  assign w_byte_addr = w_byte[ADDR_W-1:0];
  assign w_addr_nx   = r_addr + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_cs_fall ? CMD : IDLE;
      CMD:     if (w_done) w_next = (w_byte == CMD_READ || w_byte == CMD_WRITE) ? ADDR : IGNORE;
      ADDR:    if (w_done) w_next = r_op_wr ? WRITE : READ;
      default: w_next = r_state;
    endcase
    if (w_cs_rise) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_op_wr   <= 1'b0;
      spi_miso  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      r_state   <= w_next;
      wr_strobe <= 1'b0;
      if (w_cs_fall || w_cs_rise) r_bit_cnt <= '0;
      else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_byte[6:0];
      end
      if (w_cs_rise) spi_miso <= 1'b0;
      else if (w_fall && r_state == READ) begin
        spi_miso <= r_tx[7];
        r_tx     <= {r_tx[6:0], 1'b0};
      end
      if (w_done) begin
        case (r_state)
          CMD: r_op_wr <= (w_byte == CMD_WRITE);
          ADDR: begin
            r_addr <= w_byte_addr;
            if (!r_op_wr) r_tx <= r_mem[w_byte_addr];
          end
          READ: begin
            r_addr <= w_addr_nx;
            r_tx   <= r_mem[w_addr_nx];
          end
          WRITE: begin
            wr_strobe <= 1'b1;
            wr_addr   <= r_addr;
            wr_data   <= w_byte;
            r_addr    <= w_addr_nx;
          end
          default: r_op_wr <= r_op_wr;
        endcase
      end
    end
  end

  always_ff @(posedge clk) if (w_commit) r_mem[r_addr] <= w_byte;
endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: directed SPI frames against the responder with hand-computed expectations.
module tb_spi_ram_responder;
  import spi_pkg::*;
  logic clk = 1'b0;
  logic rst_n, spi_cs_n, spi_sck, spi_mosi;
  logic spi_miso, wr_strobe;
  logic [7:0] wr_addr, wr_data;
  int checks = 0;
  int failures = 0;
  int n_str = 0;
  logic [7:0] last_a = '0, last_d = '0;
  int half = 5;
  int gap = 6;

  spi_ram_responder #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) begin
    n_str++;
    last_a = wr_addr;
    last_d = wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (half) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
  endtask

  task automatic cs_hi();
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    int s0;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single write then read
    cs_lo(); xfer(8'h02, 8, rx); xfer(8'h10, 8, rx); xfer(8'hA5, 8, rx); cs_hi();
    check("wr1_count", 32'(n_str), 32'd1);
    check("wr1_addr", 32'(last_a), 32'h10);
    check("wr1_data", 32'(last_d), 32'hA5);
    cs_lo();
    xfer(8'h03, 8, rx); check("rd1_cmd_miso", 32'(rx), 32'h00);
    xfer(8'h10, 8, rx); check("rd1_addr_miso", 32'(rx), 32'h00);
    xfer(8'h00, 8, rx); check("rd1_data", 32'(rx), 32'hA5);
    cs_hi();
    check("rd1_idle_miso", 32'(spi_miso), 32'h0);

    // burst write and read wrapping past FF
    cs_lo(); xfer(8'h02, 8, rx); xfer(8'hFE, 8, rx);
    xfer(8'h11, 8, rx); xfer(8'h22, 8, rx); xfer(8'h33, 8, rx); cs_hi();
    check("burst_count", 32'(n_str), 32'd4);
    check("burst_last_addr", 32'(last_a), 32'h00);
    check("burst_last_data", 32'(last_d), 32'h33);
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'hFE, 8, rx);
    xfer(8'h00, 8, rx); check("burst_rd0", 32'(rx), 32'h11);
    xfer(8'h00, 8, rx); check("burst_rd1", 32'(rx), 32'h22);
    xfer(8'h00, 8, rx); check("burst_rd2", 32'(rx), 32'h33);
    cs_hi();
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'h00, 8, rx);
    xfer(8'h00, 8, rx); check("loc00", 32'(rx), 32'h33);
    cs_hi();

    // unknown opcode
    s0 = n_str;
    cs_lo();
    xfer(8'h9F, 8, rx); check("unk_b0", 32'(rx), 32'h00);
    xfer(8'h10, 8, rx); check("unk_b1", 32'(rx), 32'h00);
    xfer(8'hFF, 8, rx); check("unk_b2", 32'(rx), 32'h00);
    xfer(8'hFF, 8, rx); check("unk_b3", 32'(rx), 32'h00);
    cs_hi();
    check("unk_no_strobe", 32'(n_str), 32'(s0));
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'h10, 8, rx);
    xfer(8'h00, 8, rx); check("unk_mem10", 32'(rx), 32'hA5);
    cs_hi();

    // CS abort mid-byte
    cs_lo(); xfer(8'h02, 8, rx); xfer(8'h20, 8, rx); xfer(8'h77, 8, rx); cs_hi();
    s0 = n_str;
    cs_lo(); xfer(8'h02, 8, rx); xfer(8'h20, 8, rx); xfer(8'hC3, 5, rx); cs_hi();
    check("abort_no_strobe", 32'(n_str), 32'(s0));
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'h20, 8, rx);
    xfer(8'h00, 8, rx); check("abort_mem20", 32'(rx), 32'h77);
    cs_hi();

    // reset during 3rd bit of a read data byte (A5: bit5 = 1 on MISO)
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'h10, 8, rx); xfer(8'h00, 2, rx);
    check("mid_bits", 32'(rx), 32'h02);
    repeat (half) @(negedge clk);
    check("pre_rst_miso", 32'(spi_miso), 32'h1);
    spi_sck = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(spi_miso), 32'h0);
    check("midrst_state", 32'(dut.r_state), 32'(IDLE));
    spi_sck = 1'b0; spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (gap) @(negedge clk);
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'h10, 8, rx);
    xfer(8'h00, 8, rx); check("post_rst_rd", 32'(rx), 32'hA5);
    cs_hi();

    // back-to-back at minimum timing
    half = 4; gap = 4;
    s0 = n_str;
    cs_lo(); xfer(8'h02, 8, rx); xfer(8'h40, 8, rx); xfer(8'h5A, 8, rx); cs_hi();
    check("b2b_count", 32'(n_str), 32'(s0 + 1));
    check("b2b_addr", 32'(last_a), 32'h40);
    check("b2b_data", 32'(last_d), 32'h5A);
    cs_lo(); xfer(8'h03, 8, rx); xfer(8'h40, 8, rx);
    xfer(8'h00, 8, rx); check("b2b_rd", 32'(rx), 32'h5A);
    cs_hi();
    check("b2b_final_count", 32'(n_str), 32'(s0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
